grid_input_loader: RTL
======================

# grid_input_loader

Issue-side counterpart to the grid writeback stage. It accepts one RCA instruction's register-file read data and per-IO-unit routing, latches it, and dispatches each selected operand to its grid input IO unit with a per-unit valid/ready handshake. An in-flight credit counter, returned by writeback commits, limits how many dispatched instructions may be outstanding in the grid.

## Interface
Parameters:
- XLEN, 32, data width
- NUM_READ_PORTS, 5, register-file read ports per RCA instruction
- NUM_IO_UNITS, 4, grid input IO units
- MAX_INFLIGHT, 2, max dispatched-but-uncommitted instructions (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction and operands presented
- issue_ready  out  1  loader can accept (combinational)
- rs_data  in  XLEN × NUM_READ_PORTS  read-port data
- io_unit_sels  in  $clog2(NUM_READ_PORTS) × NUM_IO_UNITS  read port feeding each IO unit
- io_unit_used  in  NUM_IO_UNITS  mask of IO units this instruction drives
- io_unit_input_data  out  XLEN × NUM_IO_UNITS  registered operand per unit
- io_unit_input_valid  out  NUM_IO_UNITS  operand pending for unit
- io_unit_input_ready  in  NUM_IO_UNITS  unit accepts operand
- wb_committing  in  1  writeback committed one instruction (returns one credit)
- flush  in  1  abort current dispatch, clear credits
- busy  out  1  state is DISPATCH
- inflight_count  out  $clog2(MAX_INFLIGHT+1)  outstanding instructions

## Operation
- States: IDLE, DISPATCH.
- issue_ready = (state==IDLE) && (inflight_count < MAX_INFLIGHT) && !flush.
- Accept (issue_valid && issue_ready): for each unit i, io_unit_input_data[i] ← rs_data[io_unit_sels[i]] (0 if sel ≥ NUM_READ_PORTS); io_unit_input_valid[i] ← io_unit_used[i]; pending mask ← io_unit_used; → DISPATCH.
- DISPATCH: unit i fires when valid[i] && ready[i]; valid[i] clears next cycle; data held stable while valid[i]=1. done = no pending bit remains after this cycle's fires. On done → IDLE, inflight +1.
- Empty used mask: DISPATCH with no valids; done in first DISPATCH cycle.
- Credits: +1 on done, −1 on wb_committing (ignored at 0); simultaneous +1/−1 → unchanged. Never exceeds MAX_INFLIGHT.
- flush (any state, highest priority): next cycle state IDLE, all valids 0, pending 0, inflight 0; no done/increment that cycle; issue not accepted.
- busy = (state==DISPATCH).

## Timing
- Reset: state IDLE, all io_unit_input_valid 0, io_unit_input_data 0, pending 0, inflight_count 0, busy 0; issue_ready 1 once rst low (absent flush).
- Accept in cycle T → valids/data visible T+1.
- Unit firing in cycle T → its valid low at T+1.
- Last fire in cycle T → state IDLE and inflight incremented at T+1; earliest next accept T+1 (one idle-visible cycle between accepts minimum: accept T, all fire T+1, next accept T+2).
- Reset asserted mid-DISPATCH: all outputs to reset values immediately (asynchronous).
- issue_ready is combinational on state, inflight_count, flush; no combinational path from io_unit_input_ready to any output.

## Test plan
- Basic dispatch: rs_data={0x11,0x22,0x33,0x44,0x55}, sels={4,0,2,2}, used=4'b1111, all ready=1 → T+1 data={0x55,0x11,0x33,0x33}, valids 1111; T+2 valids 0, IDLE, inflight=1.
- Staggered ready: used=4'b0101, ready[0] at T+1, ready[2] at T+4 → valid[0] drops T+2, valid[2] held with stable data until T+5, inflight increments at T+5.
- Credit limit: MAX_INFLIGHT=2, two completed dispatches, no wb_committing → issue_ready=0; pulse wb_committing → inflight=1, issue_ready=1 next cycle; done and wb_committing same cycle → count unchanged.
- Empty mask: used=0 → no valids ever, IDLE after one DISPATCH cycle, inflight +1.
- Flush mid-dispatch: used=4'b1111, ready low, flush at T+2 with inflight=1 → T+3 valids 0, IDLE, inflight 0; issue_valid during flush not accepted.
- Async reset in DISPATCH: rst pulse between clock edges → valids, data, inflight_count, busy 0 before next edge.

Source files
------------

// File: rtl/grid_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : grid_input_loader                                                 |
// | Latches one RCA instruction's operands and dispatches them to the grid     |
// | input IO units, bounded by an in-flight credit counter.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module grid_input_loader #(
    parameter int XLEN           = 32,
    parameter int NUM_READ_PORTS = 5,
    parameter int NUM_IO_UNITS   = 4,
    parameter int MAX_INFLIGHT   = 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               issue_valid,
    output logic                                               issue_ready,
    input  logic [NUM_READ_PORTS-1:0][XLEN-1:0]                rs_data,
    input  logic [NUM_IO_UNITS-1:0][$clog2(NUM_READ_PORTS)-1:0] io_unit_sels,
    input  logic [NUM_IO_UNITS-1:0]                            io_unit_used,
    output logic [NUM_IO_UNITS-1:0][XLEN-1:0]                  io_unit_input_data,
    output logic [NUM_IO_UNITS-1:0]                            io_unit_input_valid,
    input  logic [NUM_IO_UNITS-1:0]                            io_unit_input_ready,
    input  logic                                               wb_committing,
    input  logic                                               flush,
    output logic                                               busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]                  inflight_count
);

    localparam int SEL_W = $clog2(NUM_READ_PORTS);
    localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] DISPATCH = 1'b1;

    logic [0:0]                         state;
    logic [NUM_IO_UNITS-1:0][XLEN-1:0]  sel_data;
    logic [NUM_IO_UNITS-1:0]            remaining;
    logic                               accept;
    logic                               done;
    logic                               credit_ret;
    logic [CNT_W-1:0]                   inflight_next;

    assign issue_ready = (state == IDLE) && (inflight_count < MAX_CNT) && !flush;
    assign accept      = issue_valid && issue_ready;
    assign busy        = (state == DISPATCH);

    // The valid vector doubles as the pending mask: a unit is pending until it fires.
    assign remaining  = io_unit_input_valid & ~io_unit_input_ready;
    assign done       = (state == DISPATCH) && (remaining == '0) && !flush;
    assign credit_ret = wb_committing && (inflight_count != '0);

    // Out-of-range selects match no read port and therefore yield zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IO_UNITS; i++) begin
            for (int j = 0; j < NUM_READ_PORTS; j++) begin
                if (io_unit_sels[i] == SEL_W'(j)) begin
                    sel_data[i] = rs_data[j];
                end
            end
        end
    end

    always_comb begin
        inflight_next = inflight_count;
        if (done && !credit_ret) begin
            inflight_next = inflight_count + CNT_W'(1);
        end else if (!done && credit_ret) begin
            inflight_next = inflight_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            io_unit_input_valid <= '0;
            io_unit_input_data  <= '0;
            inflight_count      <= '0;
        end else if (flush) begin
            state               <= IDLE;
            io_unit_input_valid <= '0;
            inflight_count      <= '0;
        end else begin
            inflight_count <= inflight_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        io_unit_input_data  <= sel_data;
                        io_unit_input_valid <= io_unit_used;
                        state               <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    io_unit_input_valid <= remaining;
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
